// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    // Controller states: waiting, shifting one bit per clock, result presented.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sadd_state_t;

    // Operand width used when the instantiating code does not override it.
    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Single-bit full adder cell. This is the only arithmetic in the adder;
// the controller time-multiplexes it across all operand bits.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic w_half;

    // Propagate term is shared by sum and carry.
    assign w_half = a ^ b;
    assign sum    = w_half ^ ci;
    assign co     = (a & b) | (ci & w_half);

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: captures two operands and a carry-in, feeds
// one bit pair per clock (LSB first) through a single full-adder cell, then
// presents {co, sum} with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    // Bit counter only needs to reach WIDTH-1.
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sadd_state_t      r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_done;

    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_cell_sum;
    logic             w_cell_co;
    logic [WIDTH-1:0] w_s_next;

    // start is only honoured when no add is in flight.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_shift  = (r_state == SHIFT);
    assign w_last   = w_shift && (r_cnt == CNT_LAST);

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB of
    // the result has walked down to bit 0.
    assign w_s_next = {w_cell_sum, r_s_sr[WIDTH-1:1]};

    fa_cell u_fa_cell (
        .a   (r_a_sr[0]),
        .b   (r_b_sr[0]),
        .ci  (r_carry),
        .sum (w_cell_sum),
        .co  (w_cell_co)
    );

    // State sequencing: IDLE -> SHIFT -> DONE -> (SHIFT on start | IDLE).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= start ? SHIFT : IDLE;
                SHIFT:   r_state <= w_last ? DONE : SHIFT;
                DONE:    r_state <= start ? SHIFT : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand shift registers and carry flop: loaded on accept, shifted in
    // SHIFT, otherwise held so nothing toggles while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= ci;
        end else if (w_shift) begin
            r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_carry <= w_cell_co;
        end
    end

    // Partial-sum shift register collects one cell output per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_sr <= '0;
        end else if (w_shift) begin
            r_s_sr <= w_s_next;
        end
    end

    // Bit counter: cleared on accept, advanced through SHIFT, and held at
    // WIDTH-1 on the final shift so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_shift && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result registers update only on the final shift, so the previous
    // result stays visible throughout the next add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_co  <= 1'b0;
        end else if (w_last) begin
            r_sum <= w_s_next;
            r_co  <= w_cell_co;
        end
    end

    // done is high for exactly the cycle spent in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = r_done;
    assign sum  = r_sum;
    assign co   = r_co;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       ci_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] sum_o;
    logic       co_o;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .ci    (ci_i),
        .busy  (busy_o),
        .done  (done_o),
        .sum   (sum_o),
        .co    (co_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one add and observe 10 cycles after the accepting edge.
    // busy_n/done_n count sampled cycles, done_at is the first done sample
    // index (1 = right after the accepting edge), -1 if none.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb,
                           input logic tci, output int busy_n,
                           output int done_n, output int done_at);
        @(negedge clk);
        a_i = ta; b_i = tb; ci_i = tci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int k = 1; k <= 10; k++) begin
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; a_i = 8'hFF; b_i = 8'hFF; ci_i = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        total++;
        if ({busy_o, done_o, co_o, sum_o} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b co=%b sum=%h want all 0",
                     busy_o, done_o, co_o, sum_o);
        end
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy=%b want 0", busy_o);
        end
        $display("reset: busy=%b done=%b sum=%h co=%b", busy_o, done_o, sum_o, co_o);
    endtask

    task automatic test_basic();
        int busy_n, done_n, done_at;
        logic [7:0] mid_sum;
        mid_sum = 8'h00;
        @(negedge clk);
        a_i = 8'h5A; b_i = 8'h3C; ci_i = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int k = 1; k <= 10; k++) begin
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k == 4) mid_sum = sum_o;
            @(negedge clk);
        end
        total++;
        if (mid_sum !== 8'h00) begin
            bad++;
            $display("FAIL basic_sum_held got=%h want=00", mid_sum);
        end
        total++;
        if (busy_n !== 8) begin
            bad++;
            $display("FAIL basic_busy got=%0d want=8", busy_n);
        end
        total++;
        if (done_n !== 1 || done_at !== 9) begin
            bad++;
            $display("FAIL basic_done got count=%0d at=%0d want count=1 at=9", done_n, done_at);
        end
        total++;
        if ({co_o, sum_o} !== 9'h096) begin
            bad++;
            $display("FAIL basic_result got co=%b sum=%h want co=0 sum=96", co_o, sum_o);
        end
        $display("basic: 5A+3C+0 -> co=%b sum=%h busy=%0d done_at=%0d", co_o, sum_o, busy_n, done_at);
    endtask

    task automatic test_carry();
        int busy_n, done_n, done_at;
        run_add(8'hFF, 8'h01, 1'b0, busy_n, done_n, done_at);
        total++;
        if ({co_o, sum_o} !== 9'h100 || done_n !== 1) begin
            bad++;
            $display("FAIL carry_ff_01 got co=%b sum=%h done=%0d want co=1 sum=00 done=1",
                     co_o, sum_o, done_n);
        end
        $display("carry: FF+01+0 -> co=%b sum=%h", co_o, sum_o);
        run_add(8'hFF, 8'hFF, 1'b1, busy_n, done_n, done_at);
        total++;
        if ({co_o, sum_o} !== 9'h1FF || done_n !== 1) begin
            bad++;
            $display("FAIL carry_ff_ff_1 got co=%b sum=%h done=%0d want co=1 sum=FF done=1",
                     co_o, sum_o, done_n);
        end
        $display("carry: FF+FF+1 -> co=%b sum=%h", co_o, sum_o);
    endtask

    task automatic test_ignore_start();
        int busy_n, done_n, done_at;
        @(negedge clk);
        a_i = 8'h12; b_i = 8'h34; ci_i = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int k = 1; k <= 10; k++) begin
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            a_i = 8'($urandom); b_i = 8'($urandom); ci_i = 1'($urandom);
            if (k == 3) begin
                a_i = 8'hFF; b_i = 8'hFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if ({co_o, sum_o} !== 9'h046) begin
            bad++;
            $display("FAIL ignore_result got co=%b sum=%h want co=0 sum=46", co_o, sum_o);
        end
        total++;
        if (done_n !== 1 || done_at !== 9 || busy_n !== 8) begin
            bad++;
            $display("FAIL ignore_timing got done=%0d at=%0d busy=%0d want done=1 at=9 busy=8",
                     done_n, done_at, busy_n);
        end
        $display("ignore: 12+34 with mid start -> co=%b sum=%h done=%0d", co_o, sum_o, done_n);
    endtask

    task automatic test_back_to_back();
        int busy_n, done_n, wrong_done, wrong_sum;
        busy_n = 0; done_n = 0; wrong_done = 0; wrong_sum = 0;
        @(negedge clk);
        a_i = 8'h01; b_i = 8'h01; ci_i = 1'b1; start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 27; k++) begin
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                if ((k % 9) != 0) wrong_done++;
                if ({co_o, sum_o} !== 9'h003) wrong_sum++;
            end
            if (k == 27) start = 1'b0;
            @(negedge clk);
        end
        total++;
        if (done_n !== 3 || wrong_done !== 0) begin
            bad++;
            $display("FAIL b2b_done got count=%0d misplaced=%0d want count=3 misplaced=0",
                     done_n, wrong_done);
        end
        total++;
        if (busy_n !== 24) begin
            bad++;
            $display("FAIL b2b_busy got=%0d want=24", busy_n);
        end
        total++;
        if (wrong_sum !== 0) begin
            bad++;
            $display("FAIL b2b_sum got bad_results=%0d want=0 (sum 03)", wrong_sum);
        end
        repeat (2) @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_release got busy=%b want 0", busy_o);
        end
        $display("b2b: done=%0d busy=%0d sum=%h", done_n, busy_n, sum_o);
    endtask

    task automatic test_reset_abort();
        int busy_n, done_n, done_at, stray;
        run_add(8'h10, 8'h20, 1'b0, busy_n, done_n, done_at);
        total++;
        if ({co_o, sum_o} !== 9'h030) begin
            bad++;
            $display("FAIL abort_pre got co=%b sum=%h want co=0 sum=30", co_o, sum_o);
        end
        @(negedge clk);
        a_i = 8'hAA; b_i = 8'h55; ci_i = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({busy_o, done_o, co_o, sum_o} !== 11'd0) begin
            bad++;
            $display("FAIL abort_clear got busy=%b done=%b co=%b sum=%h want all 0",
                     busy_o, done_o, co_o, sum_o);
        end
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            if (done_o || busy_o) stray++;
            @(negedge clk);
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL abort_quiet got active_cycles=%0d want=0", stray);
        end
        run_add(8'h0F, 8'h01, 1'b0, busy_n, done_n, done_at);
        total++;
        if ({co_o, sum_o} !== 9'h010 || done_n !== 1) begin
            bad++;
            $display("FAIL abort_post got co=%b sum=%h done=%0d want co=0 sum=10 done=1",
                     co_o, sum_o, done_n);
        end
        $display("abort: post-reset 0F+01 -> co=%b sum=%h", co_o, sum_o);
    endtask

    task automatic test_random();
        int busy_n, done_n, done_at;
        logic [7:0] ra, rb;
        logic       rci;
        logic [8:0] expect_v;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom);
            expect_v = {1'b0, ra} + {1'b0, rb} + {8'd0, rci};
            run_add(ra, rb, rci, busy_n, done_n, done_at);
            total++;
            if ({co_o, sum_o} !== expect_v || busy_n !== 8 || done_n !== 1 || done_at !== 9) begin
                bad++;
                $display("FAIL random_%0d %h+%h+%b got co=%b sum=%h busy=%0d done=%0d want %h busy=8 done=1",
                         n, ra, rb, rci, co_o, sum_o, busy_n, done_n, expect_v);
            end
            if (n < 5 || n == 999)
                $display("random %0d: %h+%h+%b -> co=%b sum=%h", n, ra, rb, rci, co_o, sum_o);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0; ci_i = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
